// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_pkg
// Purpose  : Shared definitions for the multicycle controller. Holds the FSM
//            state encoding, instruction opcodes, ALU operation codes, the
//            alu_src_b / pc_src / reg_dst select encodings, and the decode
//            helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_RWB      = 4'd7,
    S_EXEC_I   = 4'd8,
    S_IWB      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Instruction opcodes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // ALU operation codes (4-bit native, zero-extended to the port width)
  localparam logic [3:0] ALU_ADD  = 4'd1;   // also used for PC+4 and branch target
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_BEQ  = 4'd5;
  localparam logic [3:0] ALU_BNE  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_LUI  = 4'd9;
  localparam logic [3:0] ALU_LW   = 4'd10;
  localparam logic [3:0] ALU_SW   = 4'd11;
  localparam logic [3:0] ALU_J    = 4'd12;
  localparam logic [3:0] ALU_JAL  = 4'd13;
  localparam logic [3:0] ALU_R    = 4'd15;

  // alu_src_b select
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // pc_src select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // reg_dst select
  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  // ALU operation for an immediate-format arithmetic/logic instruction.
  function automatic logic [3:0] itype_alu_op(input logic [5:0] op);
    logic [3:0] code;
    case (op)
      OP_ADDI:  code = ALU_ADD;
      OP_ANDI:  code = ALU_AND;
      OP_ORI:   code = ALU_OR;
      OP_XORI:  code = ALU_XOR;
      OP_SLTI:  code = ALU_SLT;
      OP_SLTIU: code = ALU_SLTU;
      OP_LUI:   code = ALU_LUI;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  // First execution state for a freshly fetched opcode.
  function automatic state_t dispatch_state(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:                              nxt = S_EXEC_R;
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:               nxt = S_EXEC_I;
      OP_LW, OP_SW:                          nxt = S_MEM_ADDR;
      OP_BEQ, OP_BNE:                        nxt = S_BRANCH;
      OP_J, OP_JAL:                          nxt = S_JUMP;
      default:                               nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mc_wait_timer
// Purpose  : Counts memory wait cycles and flags the cycle on which the
//            MEM_TIMEOUT-th consecutive wait occurs.
// Ports    : clk     - clock
//            rst     - asynchronous active-high reset
//            clear   - restart the count (state is being entered/left)
//            tick    - this cycle is a wait cycle (request pending, not ready)
//            expired - this wait cycle is the MEM_TIMEOUT-th one
// Revision : 1.0 - initial release
// ============================================================================
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  // Count only has to reach MEM_TIMEOUT-1; the next tick is the expiry.
  localparam int COUNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (tick) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign expired = tick && (r_count == COUNT_W'(MEM_TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Control FSM for a multicycle MIPS-style datapath. Moore outputs
//            decoded from the current state and the opcode latched in DECODE;
//            ir_write/pc_write and the retire count are additionally qualified
//            by mem_ready or zero. Memory waits are bounded by a timeout that
//            drops the FSM into a sticky TRAP state.
// Ports    : clk, rst (async, active-high)
//            opcode, zero, mem_ready            - datapath status inputs
//            mem_req, mem_we, iord, ir_write,
//            pc_write, reg_write, mem_to_reg,
//            alu_src_a                          - 1-bit strobes / selects
//            reg_dst, alu_src_b, pc_src         - 2-bit selects
//            alu_op                             - ALU operation (zero-extended)
//            state                              - current state, debug
//            trap                               - sticky error flag
//            instr_count                        - retired instruction count
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_W     = 4,   // must be >= 4
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         reg_dst,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state,
  output logic               trap,
  output logic [CNT_W-1:0]   instr_count
);

  state_t             r_state;
  state_t             w_next_state;
  logic [5:0]         r_opcode;
  logic [3:0]         w_alu_code;
  logic               w_retire;
  logic               w_wait_state;
  logic               w_tick;
  logic               w_clear;
  logic               w_expired;
  logic [CNT_W-1:0]   r_instr_count;

  // --------------------------------------------------------------------------
  // Wait timer: only states that hold mem_req high may wait, so mem_ready is
  // never looked at elsewhere. The count restarts whenever the state changes.
  // --------------------------------------------------------------------------
  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);
  assign w_tick       = w_wait_state && !mem_ready;
  assign w_clear      = (w_next_state != r_state);

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .tick    (w_tick),
    .expired (w_expired)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Opcode is captured in DECODE so later states are immune to IR changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= '0;
    end else if (r_state == S_DECODE) begin
      r_opcode <= opcode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. DECODE dispatches on the live opcode, which is the
  // same value being latched on this edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next_state = S_DECODE;
        else if (w_expired) w_next_state = S_TRAP;
      end
      S_DECODE:   w_next_state = dispatch_state(opcode);
      S_MEM_ADDR: w_next_state = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)      w_next_state = S_MEM_WB;
        else if (w_expired) w_next_state = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready)      w_next_state = S_FETCH;
        else if (w_expired) w_next_state = S_TRAP;
      end
      S_EXEC_R:   w_next_state = S_RWB;
      S_EXEC_I:   w_next_state = S_IWB;
      S_MEM_WB,
      S_RWB,
      S_IWB,
      S_BRANCH,
      S_JUMP:     w_next_state = S_FETCH;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_TRAP;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = REGDST_RT;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    w_alu_code = 4'd0;
    trap       = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      S_FETCH: begin
        // IR load and PC+4 commit only on the cycle the fetch completes.
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        w_alu_code = ALU_ADD;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        alu_src_b  = SRCB_IMM_SH2;
        w_alu_code = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        w_alu_code = (r_opcode == OP_LW) ? ALU_LW : ALU_SW;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        iord     = 1'b1;
        w_retire = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        w_alu_code = ALU_R;
      end
      S_RWB: begin
        reg_dst   = REGDST_RD;
        reg_write = 1'b1;
        w_retire  = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        w_alu_code = itype_alu_op(r_opcode);
      end
      S_IWB: begin
        reg_dst   = REGDST_RT;
        reg_write = 1'b1;
        w_retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        w_alu_code = (r_opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
        pc_write   = (r_opcode == OP_BNE) ? ~zero : zero;
        w_retire   = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        w_alu_code = (r_opcode == OP_JAL) ? ALU_JAL : ALU_J;
        w_retire   = 1'b1;
        if (r_opcode == OP_JAL) begin
          // Link: write return address to r31.
          reg_write = 1'b1;
          reg_dst   = REGDST_R31;
        end
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        trap = 1'b0;
      end
    endcase
  end

  assign alu_op      = ALUOP_W'(w_alu_code);
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control. Each instruction is
//            expanded into per-cycle stimulus and expected-output records that
//            are queued, then replayed and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int AW = 5;    // wider than 4 so zero-extension is visible
  localparam int CW = 4;    // small counter so wrap-around is reached
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    opcode = 6'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic          mem_to_reg, alu_src_a, trap;
  logic [1:0]    reg_dst, alu_src_b, pc_src;
  logic [AW-1:0] alu_op;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_control #(
    .ALUOP_W     (AW),
    .CNT_W       (CW),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .reg_dst     (reg_dst),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .alu_op      (alu_op),
    .state       (state),
    .trap        (trap),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic          trap;
    logic          mem_req;
    logic          mem_we;
    logic          iord;
    logic          ir_write;
    logic          pc_write;
    logic          reg_write;
    logic          mem_to_reg;
    logic          alu_src_a;
    logic [1:0]    reg_dst;
    logic [1:0]    alu_src_b;
    logic [1:0]    pc_src;
    logic [AW-1:0] alu_op;
    logic [CW-1:0] cnt;
    logic          alu_dc;   // alu_op not compared in this cycle
  } rec_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] op;
    logic       z;
  } stim_t;

  rec_t          exp_q[$];
  stim_t         stim_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] m_cnt = '0;

  // ---------------------------------------------------------------- model
  function automatic logic [3:0] tb_itype_alu(input logic [5:0] op);
    case (op)
      6'd8:    return 4'd1;   // addi
      6'd12:   return 4'd2;   // andi
      6'd13:   return 4'd3;   // ori
      6'd14:   return 4'd4;   // xori
      6'd10:   return 4'd7;   // slti
      6'd11:   return 4'd8;   // sltiu
      6'd15:   return 4'd9;   // lui
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] tb_first_state(input logic [5:0] op);
    if (op == 6'd0)                               return 4'd6;
    if (op == 6'd8 || (op >= 6'd10 && op <= 6'd15)) return 4'd8;
    if (op == 6'd35 || op == 6'd43)               return 4'd2;
    if (op == 6'd4 || op == 6'd5)                 return 4'd10;
    if (op == 6'd2 || op == 6'd3)                 return 4'd11;
    return 4'd12;
  endfunction

  function automatic rec_t mk(input logic [3:0] st, input logic [5:0] lop,
                              input logic z, input logic rdy);
    rec_t e;
    e    = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.mem_req = 1; e.alu_src_b = 2'd1; e.alu_op = AW'(1);
                   e.ir_write = rdy; e.pc_write = rdy; end
      4'd1:  begin e.alu_src_b = 2'd3; e.alu_op = AW'(1); end
      4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2;
                   e.alu_op = (lop == 6'd35) ? AW'(10) : AW'(11); end
      4'd3:  begin e.mem_req = 1; e.iord = 1; end
      4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      4'd5:  begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
      4'd6:  begin e.alu_src_a = 1; e.alu_op = AW'(15); end
      4'd7:  begin e.reg_dst = 2'd1; e.reg_write = 1; end
      4'd8:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = AW'(tb_itype_alu(lop)); end
      4'd9:  begin e.reg_write = 1; end
      4'd10: begin e.alu_src_a = 1; e.pc_src = 2'd1;
                   e.alu_op   = (lop == 6'd5) ? AW'(6) : AW'(5);
                   e.pc_write = (lop == 6'd5) ? ~z : z; end
      4'd11: begin e.pc_src = 2'd2; e.pc_write = 1; e.alu_dc = 1;
                   if (lop == 6'd3) begin e.reg_write = 1; e.reg_dst = 2'd2; end end
      4'd12: begin e.trap = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic rec_t sample();
    rec_t g;
    g = '0;
    g.st = state; g.trap = trap; g.mem_req = mem_req; g.mem_we = mem_we;
    g.iord = iord; g.ir_write = ir_write; g.pc_write = pc_write;
    g.reg_write = reg_write; g.mem_to_reg = mem_to_reg; g.alu_src_a = alu_src_a;
    g.reg_dst = reg_dst; g.alu_src_b = alu_src_b; g.pc_src = pc_src;
    g.alu_op = alu_op; g.cnt = instr_count;
    return g;
  endfunction

  // Queue one cycle; non-DECODE cycles get a junk opcode on the bus.
  task automatic push1(input logic [3:0] st, input logic [5:0] lop, input logic z,
                       input logic rdy, input logic retire);
    rec_t  e;
    stim_t s;
    e     = mk(st, lop, z, rdy);
    e.cnt = m_cnt;
    s.rdy = rdy;
    s.op  = (st == 4'd1) ? lop : 6'($urandom);
    s.z   = z;
    exp_q.push_back(e);
    stim_q.push_back(s);
    if (retire) m_cnt = m_cnt + CW'(1);
  endtask

  task automatic push_traps();
    for (int i = 0; i < 3; i++) push1(4'd12, 6'd0, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // n not-ready cycles then a ready one, unless n reaches the timeout.
  task automatic push_wait(input logic [3:0] st, input logic [5:0] lop, input int n,
                           input logic retire_on_ready, output bit trapped);
    trapped = (n >= TO);
    for (int i = 0; i < ((n >= TO) ? TO : n); i++) push1(st, lop, 1'b0, 1'b0, 1'b0);
    if (trapped) push_traps();
    else         push1(st, lop, 1'b0, 1'b1, retire_on_ready);
  endtask

  task automatic push_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    bit tr;
    push_wait(4'd0, op, fw, 1'b0, tr);
    if (tr) return;
    push1(4'd1, op, z, 1'($urandom), 1'b0);
    case (tb_first_state(op))
      4'd6:  begin push1(4'd6, op, z, 1'($urandom), 0); push1(4'd7, op, z, 1'($urandom), 1); end
      4'd8:  begin push1(4'd8, op, z, 1'($urandom), 0); push1(4'd9, op, z, 1'($urandom), 1); end
      4'd2:  begin
        push1(4'd2, op, z, 1'($urandom), 0);
        if (op == 6'd35) begin
          push_wait(4'd3, op, mw, 1'b0, tr);
          if (!tr) push1(4'd4, op, z, 1'($urandom), 1);
        end else begin
          push_wait(4'd5, op, mw, 1'b1, tr);
        end
      end
      4'd10: push1(4'd10, op, z, 1'($urandom), 1);
      4'd11: push1(4'd11, op, z, 1'($urandom), 1);
      default: push_traps();
    endcase
  endtask

  // Replay queued stimulus; compare every cycle at the falling edge.
  task automatic drain(input string tag);
    int    cyc;
    stim_t s;
    rec_t  e, g;
    cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      mem_ready = s.rdy;
      opcode    = s.op;
      zero      = s.z;
      @(negedge clk);
      g = sample();
      g.alu_dc = e.alu_dc;
      if (e.alu_dc) g.alu_op = e.alu_op;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got state=%0d rec=%h, expected state=%0d rec=%h",
                 tag, cyc, g.st, g, e.st, e);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input string tag);
    rec_t e, g;
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    e = mk(4'd0, 6'd0, 1'b0, 1'b0);
    g = sample();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d rec=%h, expected state=%0d rec=%h", tag, g.st, g, e.st, e);
    end
    rst   = 1'b0;
    m_cnt = '0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_rtype();
    push_instr(6'd0, 1'b0, 0, 0);
    drain("add");
    checks++;
    if (instr_count !== CW'(1)) begin
      errors++;
      $display("FAIL add_count: got %0d, expected 1", instr_count);
    end
  endtask

  task automatic test_itype();
    logic [5:0] ops[7] = '{6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15};
    for (int i = 0; i < 7; i++) push_instr(ops[i], 1'b0, $urandom_range(0, 2), 0);
    drain("itype");
  endtask

  task automatic test_lw();
    push_instr(6'd35, 1'b0, 0, 2);
    drain("lw_wait2");
  endtask

  task automatic test_sw();
    push_instr(6'd43, 1'b0, 1, 3);
    drain("sw");
  endtask

  task automatic test_branch();
    push_instr(6'd4, 1'b0, 0, 0);
    push_instr(6'd5, 1'b0, 0, 0);
    push_instr(6'd4, 1'b1, 0, 0);
    push_instr(6'd5, 1'b1, 0, 0);
    drain("branch");
  endtask

  task automatic test_jump();
    push_instr(6'd2, 1'b0, 0, 0);
    push_instr(6'd3, 1'b0, 0, 0);
    drain("jump");
  endtask

  task automatic test_wait_boundary();
    push_instr(6'd35, 1'b0, TO - 1, TO - 1);
    push_instr(6'd43, 1'b0, TO - 1, TO - 1);
    drain("wait_max");
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal[14] = '{6'd0, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
                              6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
    for (int i = 0; i < 24; i++)
      push_instr(legal[$urandom_range(0, 13)], 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3));
    drain("b2b");
  endtask

  task automatic test_reset_mid_wr();
    push1(4'd0, 6'd43, 1'b0, 1'b1, 1'b0);
    push1(4'd1, 6'd43, 1'b0, 1'b1, 1'b0);
    push1(4'd2, 6'd43, 1'b0, 1'b1, 1'b0);
    push1(4'd5, 6'd43, 1'b0, 1'b0, 1'b0);
    drain("sw_pre_rst");
    mem_ready = 1'b0;
    #2;
    checks++;
    if (mem_we !== 1'b1 || state !== 4'd5) begin
      errors++;
      $display("FAIL mid_wr_before: got mem_we=%0b state=%0d, expected 1 and 5", mem_we, state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || state !== 4'd0 || mem_req !== 1'b1 || instr_count !== '0) begin
      errors++;
      $display("FAIL mid_wr_async: got mem_we=%0b state=%0d mem_req=%0b cnt=%0d, expected 0 0 1 0",
               mem_we, state, mem_req, instr_count);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cnt = '0;
    push_instr(6'd0, 1'b0, 0, 0);
    drain("after_mid_rst");
  endtask

  task automatic test_illegal();
    push_instr(6'd63, 1'b0, 0, 0);
    drain("illegal63");
    do_reset("reset_after_trap");
    push_instr(6'd9, 1'b0, 1, 0);
    drain("illegal9");
    do_reset("reset_after_trap9");
  endtask

  task automatic test_timeout();
    push_instr(6'd0, 1'b0, TO, 0);
    drain("fetch_timeout");
    do_reset("reset_after_fetch_to");
    push_instr(6'd35, 1'b0, 0, TO);
    drain("rd_timeout");
    do_reset("reset_after_rd_to");
    push_instr(6'd43, 1'b0, 0, TO);
    drain("wr_timeout");
    do_reset("reset_after_wr_to");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_wait_boundary();
    test_back_to_back();
    test_reset_mid_wr();
    test_illegal();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
